// File: rtl/accumulator_pkg.sv
// Shared helpers and FSM encoding for the parallel-lane accumulator and its adder tree.
package accumulator_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Width of one tree output: every reduction level adds one carry bit.
  function automatic int sum_width(input int data_w, input int lanes);
    return data_w + clog2(lanes);
  endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Registered reduction tree: an input register stage followed by clog2(LANES) adder levels,
// with a valid bit travelling alongside each stage.
module adder_tree_pipe
  import accumulator_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [LANES*DATA_W-1:0]               data,
  input  logic                                  data_valid,
  output logic [sum_width(DATA_W, LANES)-1:0]   sum,
  output logic                                  sum_valid,
  output logic                                  busy
);

  localparam int LEVELS = clog2(LANES);

  logic [LEVELS:0] stage_valid;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = LANES >> l;
    localparam int W = DATA_W + l;

    logic [N*W-1:0] node;
    logic           vld;

    assign stage_valid[l] = vld;

    if (l == 0) begin : g_in
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          node <= '0;
          vld  <= 1'b0;
        end else begin
          vld <= data_valid;
          if (data_valid) node <= data;
        end
      end
    end else begin : g_add
      // Pairwise sums of the previous level, each result one bit wider than its operands.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          node <= '0;
          vld  <= 1'b0;
        end else begin
          vld <= g_lvl[l-1].vld;
          if (g_lvl[l-1].vld) begin
            for (int j = 0; j < N; j++) begin
              node[j*W +: W] <= W'(g_lvl[l-1].node[(2*j)*(W-1) +: (W-1)])
                              + W'(g_lvl[l-1].node[(2*j+1)*(W-1) +: (W-1)]);
            end
          end
        end
      end
    end
  end

  assign sum       = g_lvl[LEVELS].node;
  assign sum_valid = g_lvl[LEVELS].vld;
  assign busy      = |stage_valid;

endmodule

// File: rtl/accumulator_par_pipe.sv
// Frame accumulator: sums BEATS beats of LANES words through a pipelined tree and
// hands the frame total to a valid/ready consumer before starting the next frame.
module accumulator_par_pipe
  import accumulator_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int BEATS  = 1024,
  parameter int ACC_W  = 32,
  parameter int SAT    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] load,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [ACC_W-1:0]        result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    overflow
);

  localparam int SUM_W = sum_width(DATA_W, LANES);
  localparam int CNT_W = clog2(BEATS + 1);
  localparam int ADD_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic [SUM_W-1:0] tree_sum;
  logic             tree_valid;
  logic             tree_busy;
  logic             add_busy;
  logic             frame_clear;
  logic [ADD_W-1:0] add_full;
  logic             carry;

  assign accept      = load_valid && load_ready;
  assign frame_clear = (state == ST_DONE) && result_ready;
  assign add_full    = ADD_W'(result) + ADD_W'(tree_sum);
  assign carry       = |add_full[ADD_W-1:ACC_W];

  adder_tree_pipe #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_tree (
    .clk        (clk),
    .reset      (reset),
    .data       (load),
    .data_valid (accept),
    .sum        (tree_sum),
    .sum_valid  (tree_valid),
    .busy       (tree_busy)
  );

  // Beats are admitted only in ACCUM, so the tree is empty whenever a frame is drained or consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ACCUM;
      count        <= '0;
      load_ready   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          load_ready <= 1'b1;
          if (accept) begin
            count <= count + 1'b1;
            if (count == LAST_BEAT) begin
              state      <= ST_DRAIN;
              load_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!tree_busy && !add_busy) begin
            state        <= ST_DONE;
            result_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            state        <= ST_ACCUM;
            result_valid <= 1'b0;
            load_ready   <= 1'b1;
            count        <= '0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  // The result register is the accumulator itself; add_busy covers the add in flight after the tree empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      overflow <= 1'b0;
      add_busy <= 1'b0;
    end else begin
      add_busy <= tree_valid;
      if (frame_clear) begin
        result   <= '0;
        overflow <= 1'b0;
      end else if (tree_valid) begin
        if (SAT != 0 && carry) begin
          result   <= '1;
          overflow <= 1'b1;
        end else begin
          result <= add_full[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulator_par_pipe.sv
// Drives five differently parameterised accumulators from one shared stimulus bus and
// compares every frame against an arithmetic model of the frame sum.
module tb_accumulator_par_pipe;

  localparam int LANES_OF[5] = '{4, 4, 4, 4, 1};
  localparam int BEATS_OF[5] = '{1024, 4, 8, 8, 1};
  localparam int ACCW_OF[5]  = '{32, 32, 20, 20, 32};
  localparam int SAT_OF[5]   = '{0, 0, 1, 0, 0};
  localparam int LAT_OF[5]   = '{3, 3, 3, 3, 1};

  typedef struct {
    logic [2:0]  sel;
    bit          rnd;
    logic [15:0] cval;
    bit          gaps;
    int          stall;
    logic [63:0] exp_res;
    bit          exp_ovf;
    bit          use_model;
  } vec_t;

  logic        clk_tb;
  logic        reset;
  logic [2:0]  sel;
  logic [63:0] load_bus;
  logic        load_valid;
  logic        result_ready;
  logic [4:0]  lv, lr, rv, rr, ovf;
  logic [31:0] res0, res1, res4;
  logic [19:0] res2, res3;
  logic        cur_ready, cur_rv, cur_ovf;
  logic [31:0] cur_res;

  int checks = 0;
  int errors = 0;

  assign lv = load_valid ? 5'(5'b1 << sel) : 5'b0;
  assign rr = result_ready ? 5'(5'b1 << sel) : 5'b0;

  always_comb begin
    cur_ready = lr[sel];
    cur_rv    = rv[sel];
    cur_ovf   = ovf[sel];
    case (sel)
      3'd0:    cur_res = res0;
      3'd1:    cur_res = res1;
      3'd2:    cur_res = {12'b0, res2};
      3'd3:    cur_res = {12'b0, res3};
      default: cur_res = res4;
    endcase
  end

  accumulator_par_pipe #(.DATA_W(16), .LANES(4), .BEATS(1024), .ACC_W(32), .SAT(0)) u_def (
    .clk(clk_tb), .reset(reset), .load(load_bus), .load_valid(lv[0]), .load_ready(lr[0]),
    .result(res0), .result_valid(rv[0]), .result_ready(rr[0]), .overflow(ovf[0]));

  accumulator_par_pipe #(.DATA_W(16), .LANES(4), .BEATS(4), .ACC_W(32), .SAT(0)) u_small (
    .clk(clk_tb), .reset(reset), .load(load_bus), .load_valid(lv[1]), .load_ready(lr[1]),
    .result(res1), .result_valid(rv[1]), .result_ready(rr[1]), .overflow(ovf[1]));

  accumulator_par_pipe #(.DATA_W(16), .LANES(4), .BEATS(8), .ACC_W(20), .SAT(1)) u_sat (
    .clk(clk_tb), .reset(reset), .load(load_bus), .load_valid(lv[2]), .load_ready(lr[2]),
    .result(res2), .result_valid(rv[2]), .result_ready(rr[2]), .overflow(ovf[2]));

  accumulator_par_pipe #(.DATA_W(16), .LANES(4), .BEATS(8), .ACC_W(20), .SAT(0)) u_wrap (
    .clk(clk_tb), .reset(reset), .load(load_bus), .load_valid(lv[3]), .load_ready(lr[3]),
    .result(res3), .result_valid(rv[3]), .result_ready(rr[3]), .overflow(ovf[3]));

  accumulator_par_pipe #(.DATA_W(16), .LANES(1), .BEATS(1), .ACC_W(32), .SAT(0)) u_one (
    .clk(clk_tb), .reset(reset), .load(load_bus[15:0]), .load_valid(lv[4]), .load_ready(lr[4]),
    .result(res4), .result_valid(rv[4]), .result_ready(rr[4]), .overflow(ovf[4]));

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Frame sum as plain arithmetic: clamp or wrap the exact total at the configured width.
  function automatic logic [63:0] model_expect(input logic [2:0] s, input logic [63:0] total, output bit ovf_o);
    logic [63:0] maxv;
    maxv = (64'd1 << ACCW_OF[s]) - 64'd1;
    if (SAT_OF[s] != 0) begin
      ovf_o = (total > maxv);
      return ovf_o ? maxv : total;
    end
    ovf_o = 1'b0;
    return total & maxv;
  endfunction

  task automatic apply_stimulus(input string tag, input vec_t v, input int abort_after);
    int          accepted;
    int          cyc;
    int          lat;
    int          bad_ready;
    int          bad_hold;
    int          beats;
    logic [63:0] msum;
    logic [63:0] exp_res;
    bit          exp_ovf;
    logic [15:0] w;
    logic [15:0] words[4];
    logic        ready_s;
    logic [31:0] held;
    logic        held_ovf;

    accepted  = 0;
    cyc       = 0;
    bad_ready = 0;
    bad_hold  = 0;
    msum      = '0;
    sel       = v.sel;
    beats     = (abort_after > 0) ? abort_after : BEATS_OF[v.sel];

    while (accepted < beats) begin
      @(negedge clk_tb);
      cyc++;
      if (cyc > beats * 4 + 100) begin
        check_output({tag, "_accept_timeout"}, 64'(accepted), 64'(beats));
        load_valid = 1'b0;
        return;
      end
      load_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int l = 0; l < 4; l++) begin
        w = v.rnd ? 16'($urandom_range(0, 65535)) : v.cval;
        words[l] = w;
        load_bus[l*16 +: 16] = w;
      end
      ready_s = cur_ready;
      @(posedge clk_tb);
      if (load_valid && ready_s) begin
        accepted++;
        for (int l = 0; l < LANES_OF[v.sel]; l++) msum += 64'(words[l]);
      end
    end
    #1 load_valid = 1'b0;
    if (abort_after > 0) return;

    lat = 0;
    forever begin
      @(posedge clk_tb);
      lat++;
      @(negedge clk_tb);
      if (cur_rv) break;
      if (cur_ready) bad_ready++;
      if (lat > 400) break;
    end
    check_output({tag, "_latency"}, 64'(lat), 64'(LAT_OF[v.sel] + 2));

    held     = cur_res;
    held_ovf = cur_ovf;
    repeat (v.stall) begin
      @(negedge clk_tb);
      if (cur_res !== held || cur_ovf !== held_ovf || !cur_rv) bad_hold++;
      if (cur_ready) bad_ready++;
    end

    exp_res = model_expect(v.sel, msum, exp_ovf);
    if (!v.use_model) begin
      exp_res = v.exp_res;
      exp_ovf = v.exp_ovf;
    end
    check_output({tag, "_result"}, 64'(cur_res), exp_res);
    check_output({tag, "_overflow"}, 64'(cur_ovf), 64'(exp_ovf));
    check_output({tag, "_ready_low_until_done"}, 64'(bad_ready), 64'd0);
    if (v.stall > 0) check_output({tag, "_held_during_stall"}, 64'(bad_hold), 64'd0);

    result_ready = 1'b1;
    @(posedge clk_tb);
    #1 result_ready = 1'b0;
    @(negedge clk_tb);
    check_output({tag, "_after_consume"}, {61'd0, cur_rv, cur_ready, cur_ovf}, 64'b010);
    check_output({tag, "_cleared"}, 64'(cur_res), 64'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'd1, 1'b0, 16'h0001, 1'b0, 0,  64'd16,         1'b0, 1'b0};
    vecs[1]  = '{3'd0, 1'b0, 16'hFFFF, 1'b0, 0,  64'h0FFF_F000,  1'b0, 1'b0};
    vecs[2]  = '{3'd0, 1'b1, 16'h0000, 1'b0, 0,  64'd0,          1'b0, 1'b1};
    vecs[3]  = '{3'd2, 1'b0, 16'hFFFF, 1'b0, 0,  64'hF_FFFF,     1'b1, 1'b0};
    vecs[4]  = '{3'd3, 1'b0, 16'hFFFF, 1'b0, 0,  64'hF_FFE0,     1'b0, 1'b0};
    vecs[5]  = '{3'd1, 1'b1, 16'h0000, 1'b1, 50, 64'd0,          1'b0, 1'b1};
    vecs[6]  = '{3'd1, 1'b0, 16'h0003, 1'b1, 0,  64'd48,         1'b0, 1'b0};
    vecs[7]  = '{3'd4, 1'b0, 16'hABCD, 1'b0, 0,  64'h0000_ABCD,  1'b0, 1'b0};
    vecs[8]  = '{3'd4, 1'b0, 16'h1234, 1'b0, 0,  64'h0000_1234,  1'b0, 1'b0};
    vecs[9]  = '{3'd2, 1'b1, 16'h0000, 1'b1, 5,  64'd0,          1'b0, 1'b1};
    vecs[10] = '{3'd3, 1'b1, 16'h0000, 1'b0, 0,  64'd0,          1'b0, 1'b1};

    reset        = 1'b1;
    sel          = 3'd0;
    load_bus     = '0;
    load_valid   = 1'b0;
    result_ready = 1'b0;

    repeat (3) @(negedge clk_tb);
    check_output("reset_flags", {49'd0, lr, rv, ovf}, 64'd0);
    check_output("reset_results", 64'(res0 | res1 | res4) | 64'(res2 | res3), 64'd0);
    reset = 1'b0;
    #1 check_output("ready_low_at_release", 64'(lr), 64'd0);
    @(negedge clk_tb);
    check_output("ready_one_clk_after_release", 64'(lr), 64'h1F);

    for (int i = 0; i < 11; i++) apply_stimulus($sformatf("vec%0d", i), vecs[i], 0);

    // Mid-frame reset: outputs must clear at once, without waiting for an edge.
    apply_stimulus("partial", vecs[1], 500);
    #2 reset = 1'b1;
    #1 check_output("midframe_reset_outputs", {31'd0, res0, lr[0], rv[0], ovf[0]}, 64'd0);
    repeat (2) @(negedge clk_tb);
    reset = 1'b0;
    @(negedge clk_tb);
    check_output("ready_after_midframe_reset", 64'(lr[0]), 64'd1);
    apply_stimulus("after_reset", '{3'd0, 1'b0, 16'h0002, 1'b0, 0, 64'd8192, 1'b0, 1'b0}, 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
